// File: rtl/prs_ber_checker_if.sv
// Decoded-bit stream and BER status bundle between the decoder chain and the PRS checker.
interface prs_ber_checker_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 i_clear;
    logic                 i_invert;
    logic                 i_vld;
    logic                 i_sym;
    logic                 o_locked;
    logic                 o_err_vld;
    logic                 o_err;
    logic [CNT_WIDTH-1:0] o_bit_cnt;
    logic [CNT_WIDTH-1:0] o_err_cnt;
    logic [7:0]           o_loss_cnt;
    logic                 o_sat;

    modport master (
        output i_clear, i_invert, i_vld, i_sym,
        input  o_locked, o_err_vld, o_err, o_bit_cnt, o_err_cnt, o_loss_cnt, o_sat
    );

    modport slave (
        input  i_clear, i_invert, i_vld, i_sym,
        output o_locked, o_err_vld, o_err, o_bit_cnt, o_err_cnt, o_loss_cnt, o_sat
    );
endinterface

// File: rtl/prs_ber_checker.sv
// PRS bit-error-rate checker: self-synchronises a local LFSR to the decoded bit stream,
// then free-runs it to count bit errors and detect loss of lock.
module prs_ber_checker #(
    parameter int PRS_ORDER = 15,
    parameter int PRS_TAP   = 14,
    parameter int CNT_WIDTH = 32,
    parameter int LOCK_LEN  = 64,
    parameter int LOSS_WIN  = 256,
    parameter int LOSS_ERR  = 16
) (
    input  logic              clk,
    input  logic              nRESET,
    prs_ber_checker_if.slave  bus
);
    localparam int FILL_W  = $clog2(PRS_ORDER + 1);
    localparam int MATCH_W = $clog2(LOCK_LEN + 1);
    localparam int WIN_W   = $clog2(LOSS_WIN + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t               state_q, state_d;
    logic [PRS_ORDER-1:0] lfsr_q, lfsr_d;
    logic [FILL_W-1:0]    fill_q, fill_d;
    logic [MATCH_W-1:0]   match_q, match_d;
    logic [WIN_W-1:0]     win_q, win_d;
    logic [WIN_W-1:0]     winErr_q, winErr_d;
    logic [WIN_W-1:0]     winErrInc;
    logic                 locked_q, locked_d;
    logic                 errVld_q, errVld_d;
    logic                 err_q, err_d;
    logic                 sat_q, sat_d;
    logic [CNT_WIDTH-1:0] bitCnt_q, bitCnt_d;
    logic [CNT_WIDTH-1:0] errCnt_q, errCnt_d;
    logic [7:0]           lossCnt_q, lossCnt_d;
    logic                 inBit, predBit, bitErr;

    // In SEARCH the register loads received bits; once locked it loads its own prediction,
    // so a single channel error never propagates into later predictions.
    always_comb begin
        inBit     = bus.i_sym ^ bus.i_invert;
        predBit   = lfsr_q[PRS_ORDER-1] ^ lfsr_q[PRS_TAP-1];
        bitErr    = inBit ^ predBit;
        winErrInc = winErr_q + WIN_W'(bitErr);

        state_d   = state_q;
        lfsr_d    = lfsr_q;
        fill_d    = fill_q;
        match_d   = match_q;
        win_d     = win_q;
        winErr_d  = winErr_q;
        locked_d  = locked_q;
        errVld_d  = 1'b0;
        err_d     = 1'b0;
        sat_d     = sat_q;
        bitCnt_d  = bitCnt_q;
        errCnt_d  = errCnt_q;
        lossCnt_d = lossCnt_q;

        if (bus.i_vld) begin
            if (state_q == SEARCH) begin
                lfsr_d = {lfsr_q[PRS_ORDER-2:0], inBit};
                if (fill_q < FILL_W'(PRS_ORDER)) begin
                    fill_d = fill_q + 1'b1;
                end else if (!bitErr && (lfsr_q != '0)) begin
                    match_d = match_q + 1'b1;
                    if (match_d == MATCH_W'(LOCK_LEN)) begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                        match_d  = '0;
                        win_d    = '0;
                        winErr_d = '0;
                    end
                end else begin
                    match_d = '0;
                end
            end else begin
                lfsr_d   = {lfsr_q[PRS_ORDER-2:0], predBit};
                errVld_d = 1'b1;
                err_d    = bitErr;
                bitCnt_d = (bitCnt_q == CNT_MAX) ? bitCnt_q : bitCnt_q + 1'b1;
                errCnt_d = (bitErr && (errCnt_q != CNT_MAX)) ? errCnt_q + 1'b1 : errCnt_q;
                sat_d    = sat_q | (bitCnt_d == CNT_MAX) | (errCnt_d == CNT_MAX);
                // The window's last bit is judged including its own error.
                if (win_q == WIN_W'(LOSS_WIN - 1)) begin
                    win_d    = '0;
                    winErr_d = '0;
                    if (winErrInc >= WIN_W'(LOSS_ERR)) begin
                        state_d   = SEARCH;
                        locked_d  = 1'b0;
                        fill_d    = '0;
                        match_d   = '0;
                        lossCnt_d = (lossCnt_q == 8'hFF) ? lossCnt_q : lossCnt_q + 1'b1;
                    end
                end else begin
                    win_d    = win_q + 1'b1;
                    winErr_d = winErrInc;
                end
            end
        end

        if (bus.i_clear) begin
            bitCnt_d = '0;
            errCnt_d = '0;
            sat_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!nRESET) begin
            state_q   <= SEARCH;
            lfsr_q    <= '0;
            fill_q    <= '0;
            match_q   <= '0;
            win_q     <= '0;
            winErr_q  <= '0;
            locked_q  <= 1'b0;
            errVld_q  <= 1'b0;
            err_q     <= 1'b0;
            sat_q     <= 1'b0;
            bitCnt_q  <= '0;
            errCnt_q  <= '0;
            lossCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            win_q     <= win_d;
            winErr_q  <= winErr_d;
            locked_q  <= locked_d;
            errVld_q  <= errVld_d;
            err_q     <= err_d;
            sat_q     <= sat_d;
            bitCnt_q  <= bitCnt_d;
            errCnt_q  <= errCnt_d;
            lossCnt_q <= lossCnt_d;
        end
    end

    assign bus.o_locked   = locked_q;
    assign bus.o_err_vld  = errVld_q;
    assign bus.o_err      = err_q;
    assign bus.o_bit_cnt  = bitCnt_q;
    assign bus.o_err_cnt  = errCnt_q;
    assign bus.o_loss_cnt = lossCnt_q;
    assign bus.o_sat      = sat_q;
endmodule

// File: tb/tb_prs_ber_checker.sv
// Directed bench for prs_ber_checker: a 32-bit and an 8-bit counter instance share one stimulus stream.
module tb_prs_ber_checker;
    logic        clk = 1'b0;
    logic        nRESET;
    int          checks = 0;
    int          errors = 0;
    logic [14:0] prsState;
    logic        lastErrVld;
    logic        lastErr;
    logic        sawLocked;
    int          pulses;
    int          strayPulses;

    prs_ber_checker_if #(.CNT_WIDTH(32)) bus ();
    prs_ber_checker_if #(.CNT_WIDTH(8))  bus8 ();

    assign bus8.i_clear  = bus.i_clear;
    assign bus8.i_invert = bus.i_invert;
    assign bus8.i_vld    = bus.i_vld;
    assign bus8.i_sym    = bus.i_sym;

    prs_ber_checker #(.CNT_WIDTH(32)) dut (.clk(clk), .nRESET(nRESET), .bus(bus));
    prs_ber_checker #(.CNT_WIDTH(8))  dut8 (.clk(clk), .nRESET(nRESET), .bus(bus8));

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference PRS15 source, x^15 + x^14 + 1, newest bit in bit 0.
    task automatic nextPrs(output logic bitOut);
        bitOut   = prsState[14] ^ prsState[13];
        prsState = {prsState[13:0], bitOut};
    endtask

    task automatic applyStimulus(input logic sym, input logic flipped, input int gap, input logic clr);
        bus.i_vld   = 1'b1;
        bus.i_sym   = sym;
        bus.i_clear = clr;
        @(posedge clk);
        #1;
        bus.i_vld   = 1'b0;
        bus.i_clear = 1'b0;
        lastErrVld  = bus.o_err_vld;
        lastErr     = bus.o_err;
        if (bus.o_locked) sawLocked = 1'b1;
        if (lastErrVld && lastErr) begin
            pulses++;
            if (!flipped) strayPulses++;
        end
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sendPrs(input int n, input int gap, input logic inv, input int flipEvery, input int flipFirst);
        logic bt;
        logic flip;
        for (int i = 0; i < n; i++) begin
            nextPrs(bt);
            flip = (i < flipFirst) || ((flipEvery > 0) && ((i % flipEvery) == flipEvery - 1));
            applyStimulus(bt ^ inv ^ flip, flip, gap, 1'b0);
        end
    endtask

    task automatic doReset();
        nRESET       = 1'b0;
        bus.i_clear  = 1'b0;
        bus.i_invert = 1'b0;
        bus.i_vld    = 1'b0;
        bus.i_sym    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nRESET   = 1'b1;
        prsState = 15'h0001;
    endtask

    initial begin
        logic bt;
        doReset();
        checkOutput("reset_locked", 32'(bus.o_locked), 32'd0);
        checkOutput("reset_err_vld", 32'(bus.o_err_vld), 32'd0);
        checkOutput("reset_bit_cnt", bus.o_bit_cnt, 32'd0);
        checkOutput("reset_err_cnt", bus.o_err_cnt, 32'd0);
        checkOutput("reset_loss_cnt", 32'(bus.o_loss_cnt), 32'd0);
        checkOutput("reset_sat", 32'(bus.o_sat), 32'd0);

        // All-zero history must never count as a match.
        sawLocked = 1'b0;
        for (int i = 0; i < 5000; i++) applyStimulus(1'b0, 1'b0, 0, 1'b0);
        checkOutput("zeros_never_locked", 32'(sawLocked), 32'd0);
        checkOutput("zeros_bit_cnt", bus.o_bit_cnt, 32'd0);
        checkOutput("zeros_err_cnt", bus.o_err_cnt, 32'd0);

        doReset();
        pulses = 0;
        strayPulses = 0;
        sendPrs(78, 63, 1'b0, 0, 0);
        checkOutput("lock_not_before_79", 32'(bus.o_locked), 32'd0);
        sendPrs(1, 63, 1'b0, 0, 0);
        checkOutput("lock_at_79", 32'(bus.o_locked), 32'd1);
        checkOutput("search_bits_uncounted", bus.o_bit_cnt, 32'd0);
        sendPrs(1000, 0, 1'b0, 0, 0);
        checkOutput("clean_bit_cnt", bus.o_bit_cnt, 32'd1000);
        checkOutput("clean_err_cnt", bus.o_err_cnt, 32'd0);
        checkOutput("clean_loss_cnt", 32'(bus.o_loss_cnt), 32'd0);
        checkOutput("clean_last_err_vld", 32'(lastErrVld), 32'd1);
        checkOutput("clean_no_pulses", 32'(pulses), 32'd0);
        checkOutput("cnt8_saturated", 32'(bus8.o_bit_cnt), 32'd255);
        checkOutput("cnt8_sat_flag", 32'(bus8.o_sat), 32'd1);
        checkOutput("cnt32_no_sat", 32'(bus.o_sat), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("err_vld_idle_low", 32'(bus.o_err_vld), 32'd0);

        sawLocked = 1'b0;
        sendPrs(10000, 0, 1'b0, 100, 0);
        checkOutput("flip_err_cnt", bus.o_err_cnt, 32'd100);
        checkOutput("flip_bit_cnt", bus.o_bit_cnt, 32'd11000);
        checkOutput("flip_pulses", 32'(pulses), 32'd100);
        checkOutput("flip_stray_pulses", 32'(strayPulses), 32'd0);
        checkOutput("flip_still_locked", 32'(bus.o_locked), 32'd1);
        checkOutput("flip_loss_cnt", 32'(bus.o_loss_cnt), 32'd0);

        // 11000 locked bits leaves the window at position 248; finish it, then burst a fresh one.
        sendPrs(8, 0, 1'b0, 0, 0);
        sendPrs(255, 0, 1'b0, 0, 20);
        checkOutput("burst_locked_til_window_end", 32'(bus.o_locked), 32'd1);
        sendPrs(1, 0, 1'b0, 0, 0);
        checkOutput("burst_lock_lost", 32'(bus.o_locked), 32'd0);
        checkOutput("burst_loss_cnt", 32'(bus.o_loss_cnt), 32'd1);
        checkOutput("burst_err_cnt", bus.o_err_cnt, 32'd120);
        checkOutput("burst_bit_cnt", bus.o_bit_cnt, 32'd11264);
        sendPrs(78, 1, 1'b0, 0, 0);
        checkOutput("relock_not_yet", 32'(bus.o_locked), 32'd0);
        checkOutput("search_bit_cnt_held", bus.o_bit_cnt, 32'd11264);
        checkOutput("search_err_cnt_held", bus.o_err_cnt, 32'd120);
        checkOutput("search_no_err_vld", 32'(lastErrVld), 32'd0);
        sendPrs(1, 1, 1'b0, 0, 0);
        checkOutput("relock_at_79", 32'(bus.o_locked), 32'd1);

        nextPrs(bt);
        applyStimulus(bt, 1'b0, 0, 1'b1);
        checkOutput("clear_bit_cnt", bus.o_bit_cnt, 32'd0);
        checkOutput("clear_err_cnt", bus.o_err_cnt, 32'd0);
        checkOutput("clear_err_vld_pulse", 32'(lastErrVld), 32'd1);
        checkOutput("clear_keeps_lock", 32'(bus.o_locked), 32'd1);
        checkOutput("clear_cnt8_sat", 32'(bus8.o_sat), 32'd0);
        checkOutput("clear_cnt8_bits", 32'(bus8.o_bit_cnt), 32'd0);
        sendPrs(5, 0, 1'b0, 0, 0);
        checkOutput("after_clear_bit_cnt", bus.o_bit_cnt, 32'd5);
        checkOutput("after_clear_cnt8_bits", 32'(bus8.o_bit_cnt), 32'd5);

        // Reset asserted together with a valid bit must still win.
        nRESET    = 1'b0;
        bus.i_vld = 1'b1;
        @(posedge clk);
        #1;
        bus.i_vld = 1'b0;
        checkOutput("midreset_locked", 32'(bus.o_locked), 32'd0);
        checkOutput("midreset_err_vld", 32'(bus.o_err_vld), 32'd0);
        checkOutput("midreset_bit_cnt", bus.o_bit_cnt, 32'd0);
        checkOutput("midreset_loss_cnt", 32'(bus.o_loss_cnt), 32'd0);
        checkOutput("midreset_sat", 32'(bus.o_sat), 32'd0);

        doReset();
        bus.i_invert = 1'b1;
        pulses = 0;
        sendPrs(78, 0, 1'b1, 0, 0);
        checkOutput("inv_not_before_79", 32'(bus.o_locked), 32'd0);
        sendPrs(1, 0, 1'b1, 0, 0);
        checkOutput("inv_lock_at_79", 32'(bus.o_locked), 32'd1);
        sendPrs(100, 2, 1'b1, 0, 0);
        checkOutput("inv_bit_cnt", bus.o_bit_cnt, 32'd100);
        checkOutput("inv_err_cnt", bus.o_err_cnt, 32'd0);

        doReset();
        sawLocked = 1'b0;
        sendPrs(500, 0, 1'b1, 0, 0);
        checkOutput("noinv_never_locked", 32'(sawLocked), 32'd0);
        checkOutput("noinv_bit_cnt", bus.o_bit_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/prs_ber_checker.md
Name: prs_ber_checker

Overview:
- In-hardware PRS bit-error-rate checker for the decoder bench chain.
- Sits after fano_decoder's decoded-bit output, replacing the file-dump bit capture.
- Self-synchronises a local LFSR to the decoded PRS bit stream, then free-runs it.
- Counts checked bits and bit errors, and detects loss of lock, with parametrised polynomial, counter width and lock/loss criteria.

Parameters:
PRS_ORDER, 15, LFSR length (polynomial x^PRS_ORDER + x^PRS_TAP + 1)
PRS_TAP, 14, second feedback tap, 1 <= PRS_TAP < PRS_ORDER
CNT_WIDTH, 32, width of bit/error counters
LOCK_LEN, 64, consecutive matches needed to declare lock
LOSS_WIN, 256, locked-bit window length for loss detection
LOSS_ERR, 16, errors within one window that force loss of lock

Ports:
clk  in  1  clock
nRESET  in  1  synchronous active-low reset
i_clear  in  1  synchronous clear of bit/err counters and sat flag
i_invert  in  1  invert input polarity before checking
i_vld  in  1  input bit strobe
i_sym  in  1  decoded bit
o_locked  out  1  checker locked
o_err_vld  out  1  per-bit check strobe (locked bits only)
o_err  out  1  bit error flag, qualified by o_err_vld
o_bit_cnt  out  CNT_WIDTH  locked bits checked
o_err_cnt  out  CNT_WIDTH  errors among checked bits
o_loss_cnt  out  8  number of lock losses, saturating at 255
o_sat  out  1  sticky: bit or err counter saturated

Behaviour:
- Reset is nRESET, synchronous, active-low; clock is clk. Reset is honoured mid-operation.
- Reset values: all outputs 0; state SEARCH; LFSR register r = 0; fill, match, window and window-error counters = 0.
- Bit handling:
  - b = i_sym ^ i_invert.
  - r[0] holds the newest bit.
  - Predicted bit p = r[PRS_ORDER-1] ^ r[PRS_TAP-1].
  - Only cycles with i_vld = 1 advance any state.
- State SEARCH:
  - r shifts in b (self-synchronising).
  - Fill counter counts to PRS_ORDER; no comparisons are made until PRS_ORDER bits have been received.
  - After fill: if b == p and r != 0, match_cnt increments; otherwise match_cnt = 0. The zero-state guard means an all-zero history never counts as a match.
  - When match_cnt reaches LOCK_LEN, move to LOCKED.
  - o_locked = 1 is registered on the same edge as the LOCK_LEN-th match.
  - No counting and no o_err_vld while in SEARCH.
- State LOCKED:
  - r shifts in p, not b (free-run), so a channel error costs exactly one counted error.
  - Per bit: o_err_vld = 1 and o_err = b ^ p, registered one clock after the i_vld cycle. o_err_vld is otherwise 0.
  - o_bit_cnt += 1 and o_err_cnt += o_err. Both saturate at all-ones; o_sat is set sticky when either reaches all-ones.
  - Window counter counts locked bits 0..LOSS_WIN-1 and wraps. The window-error counter accumulates errors.
  - On the last bit of a window, the check includes that bit's error. If window errors >= LOSS_ERR: go to SEARCH, drop o_locked, clear fill/match, o_loss_cnt += 1 (saturating). Keep r as is.
  - Window counters clear at every wrap and on lock entry.
- i_clear:
  - Zeroes o_bit_cnt, o_err_cnt and o_sat. It does not affect state, LFSR or window counters.
  - If i_clear and i_vld occur together, clear wins: the bit advances the LFSR and window but is not added to the counters. o_err_vld still pulses.
- Latency: input bit to o_err/counter update is 1 clock.
- Back-to-back i_vld every cycle is supported; gaps of any length are allowed.

Test Plan:
- Ideal PRS15 from reset, i_vld every 64th clock -> o_locked rises after the 79th valid bit (15 fill + 64 matches); o_bit_cnt = 1000, o_err_cnt = 0 after 1000 further bits; o_loss_cnt = 0.
- Same stream with 1 bit flipped every 100 bits over 10000 locked bits -> o_err_cnt = 100, o_locked stays 1, each flip gives exactly one o_err pulse.
- 20-bit error burst inside one window -> o_locked falls at that window's last bit, o_loss_cnt = 1; relock 79 bits later; counters hold their values while in SEARCH.
- Constant-zero input for 5000 bits -> o_locked never asserts; all counters stay 0.
- Inverted PRS with i_invert = 1 -> lock after 79 bits and zero errors; with i_invert = 0 -> never locks (inverted PRS15 is not a PRS15 sequence).
- CNT_WIDTH = 8, 300 locked bits -> o_bit_cnt = 255, o_sat = 1; i_clear coincident with i_vld -> counters 0, that bit uncounted, o_locked unchanged; nRESET low mid-run -> all outputs 0 next clock.
